// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Two free-running (column, line) counter pairs: the display position (hc, vc) and a fetch
// position (fh, fv) kept FETCH_LEAD pixels ahead of it. Every output is registered from them.
// Optional feature macro: VGA_TIMING_IRQ_EN enables the sticky vblank interrupt on IRQ.
module vga_timing_gen #(
  parameter int unsigned CW         = 11,
  parameter int unsigned H_ACTIVE   = 800,
  parameter int unsigned H_FP       = 40,
  parameter int unsigned H_SYNC     = 128,
  parameter int unsigned H_BP       = 88,
  parameter int unsigned V_ACTIVE   = 600,
  parameter int unsigned V_FP       = 1,
  parameter int unsigned V_SYNC     = 4,
  parameter int unsigned V_BP       = 23,
  parameter bit          HS_POL     = 1'b1,
  parameter bit          VS_POL     = 1'b1,
  parameter int unsigned FETCH_LEAD = 2
) (
  input  logic          CLK_PIXEL,
  input  logic          RESET_N,
  output logic          Hs,
  output logic          Vs,
  output logic [CW-1:0] SCREEN_X,
  output logic [CW-1:0] SCREEN_Y,
  output logic          ON_SCREEN,
  output logic          VBLANK,
  output logic          LINE_START,
  output logic          FRAME_START,
  output logic [CW-1:0] FETCH_X,
  output logic [CW-1:0] FETCH_Y,
  output logic          FETCH_VALID,
  output logic          IRQ,
  input  logic          IRQ_ACK
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

  localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] FETCH_INIT = CW'(FETCH_LEAD);

  // Range tests are done at 32 bits so an end bound equal to 2^CW cannot wrap.
  function automatic logic in_range(input logic [CW-1:0] v, input int unsigned lo,
                                    input int unsigned hi);
    return (32'(v) >= lo) && (32'(v) < hi);
  endfunction

  logic [CW-1:0] hc_q, hc_d, vc_q, vc_d;
  logic [CW-1:0] fh_q, fh_d, fv_q, fv_d;

  // Next raster position for both counter pairs; identical wrap rules.
  always_comb begin
    hc_d = hc_q + 1'b1;
    vc_d = vc_q;
    if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end
    fh_d = fh_q + 1'b1;
    fv_d = fv_q;
    if (fh_q == H_LAST) begin
      fh_d = '0;
      fv_d = (fv_q == V_LAST) ? '0 : fv_q + 1'b1;
    end
  end

  // Counter state; the fetch pair starts FETCH_LEAD columns ahead on line 0.
  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      hc_q <= '0;
      vc_q <= '0;
      fh_q <= FETCH_INIT;
      fv_q <= '0;
    end else begin
      hc_q <= hc_d;
      vc_q <= vc_d;
      fh_q <= fh_d;
      fv_q <= fv_d;
    end
  end

  // Registered decode of the display position; syncs fall straight to idle on reset.
  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      SCREEN_X    <= '0;
      SCREEN_Y    <= '0;
      Hs          <= ~HS_POL;
      Vs          <= ~VS_POL;
      ON_SCREEN   <= 1'b0;
      VBLANK      <= 1'b0;
      LINE_START  <= 1'b0;
      FRAME_START <= 1'b0;
    end else begin
      SCREEN_X    <= hc_q;
      SCREEN_Y    <= vc_q;
      Hs          <= in_range(hc_q, HS_START, HS_END) ? HS_POL : ~HS_POL;
      Vs          <= in_range(vc_q, VS_START, VS_END) ? VS_POL : ~VS_POL;
      ON_SCREEN   <= in_range(hc_q, 0, H_ACTIVE) && in_range(vc_q, 0, V_ACTIVE);
      VBLANK      <= !in_range(vc_q, 0, V_ACTIVE);
      LINE_START  <= (hc_q == '0);
      FRAME_START <= (hc_q == '0) && (vc_q == '0);
    end
  end

  // Registered decode of the look-ahead fetch position.
  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      FETCH_X     <= '0;
      FETCH_Y     <= '0;
      FETCH_VALID <= 1'b0;
    end else begin
      FETCH_X     <= fh_q;
      FETCH_Y     <= fv_q;
      FETCH_VALID <= in_range(fh_q, 0, H_ACTIVE) && in_range(fv_q, 0, V_ACTIVE);
    end
  end

`ifdef VGA_TIMING_IRQ_EN
  logic irq_set;
  assign irq_set = (hc_q == '0) && (32'(vc_q) == V_ACTIVE);

  // Sticky vblank interrupt; a new set beats a coincident acknowledge.
  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= irq_set | (IRQ & ~IRQ_ACK);
    end
  end
`else
  logic unused_irq_ack;
  assign unused_irq_ack = IRQ_ACK;
  assign IRQ            = 1'b0;
`endif

endmodule
